// File: rtl/mem_bus_master.sv
`default_nettype none
// ============================================================================
// Module      : mem_bus_master
// Description : Core-side initiator for a 16-bit asynchronous SRAM bus.
//               Turns one 32-bit-core load/store (byte/half/word, big-endian)
//               into one or two timed 16-bit SRAM accesses and returns the
//               extended load data with a one-cycle completion pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_bus_master #(
   parameter int ADDR_W        = 18,
   parameter int ACCESS_CYCLES = 2
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [1:0]        req_size,
   input  logic              req_signed,
   input  logic [31:0]       req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   output logic              resp_err,
   output logic [31:0]       resp_rdata,
   output logic [ADDR_W-1:0] addr,
   inout  wire  [15:0]       data,
   output logic              wre,
   output logic              oute,
   output logic              chip_en,
   output logic              hb_mask,
   output logic              lb_mask
);

   localparam int c_cnt_w = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
   localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(ACCESS_CYCLES - 1);
   localparam logic [1:0] c_size_byte = 2'd0;
   localparam logic [1:0] c_size_half = 2'd1;
   localparam logic [1:0] c_size_word = 2'd2;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_PH1  = 3'd1,
      ST_GAP1 = 3'd2,
      ST_PH2  = 3'd3,
      ST_DONE = 3'd4
   } state_t;

   state_t              state_q, state_d;
   logic [c_cnt_w-1:0]  cnt_q, cnt_d;
   logic [ADDR_W-1:0]   haddr_q, haddr_d;
   logic                write_q, write_d;
   logic [1:0]          size_q, size_d;
   logic                sgn_q, sgn_d;
   logic                lane_q, lane_d;
   logic [31:0]         wdata_q, wdata_d;
   logic [15:0]         hw1_q, hw1_d;
   logic [15:0]         hw2_q, hw2_d;
   logic                err_q, err_d;

   logic                w_misaligned;
   logic                w_phase;
   logic                w_drive;
   logic [15:0]         w_wr_half;
   logic [7:0]          w_byte;

   // Byte-address bits above the SRAM halfword range simply alias (wrap).
   logic                unused_addr_bits;
   assign unused_addr_bits = ^req_addr[31:ADDR_W+1];

   assign w_misaligned = (req_size == 2'd3)
                       || ((req_size == c_size_half) && req_addr[0])
                       || ((req_size == c_size_word) && (req_addr[1:0] != 2'b00));

   // State, phase counter, captured request and captured read halfwords.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         haddr_q <= '0;
         write_q <= 1'b0;
         size_q  <= 2'd0;
         sgn_q   <= 1'b0;
         lane_q  <= 1'b0;
         wdata_q <= '0;
         hw1_q   <= '0;
         hw2_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         haddr_q <= haddr_d;
         write_q <= write_d;
         size_q  <= size_d;
         sgn_q   <= sgn_d;
         lane_q  <= lane_d;
         wdata_q <= wdata_d;
         hw1_q   <= hw1_d;
         hw2_q   <= hw2_d;
         err_q   <= err_d;
      end
   end

   // Sequencing: accept in IDLE, hold each strobe phase for ACCESS_CYCLES,
   // sample read data on the edge closing a phase, one-cycle turnaround gap.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      haddr_d = haddr_q;
      write_d = write_q;
      size_d  = size_q;
      sgn_d   = sgn_q;
      lane_d  = lane_q;
      wdata_d = wdata_q;
      hw1_d   = hw1_q;
      hw2_d   = hw2_q;
      err_d   = err_q;
      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               haddr_d = req_addr[ADDR_W:1];
               write_d = req_write;
               size_d  = req_size;
               sgn_d   = req_signed;
               lane_d  = req_addr[0];
               wdata_d = req_wdata;
               cnt_d   = '0;
               err_d   = w_misaligned;
               // Misaligned requests skip the bus entirely.
               state_d = w_misaligned ? ST_DONE : ST_PH1;
            end
         end
         ST_PH1: begin
            if (cnt_q == c_cnt_last) begin
               cnt_d = '0;
               if (!write_q) begin
                  hw1_d = data;
               end
               state_d = (size_q == c_size_word) ? ST_GAP1 : ST_DONE;
            end else begin
               cnt_d = cnt_q + c_cnt_w'(1);
            end
         end
         ST_GAP1: begin
            state_d = ST_PH2;
         end
         ST_PH2: begin
            if (cnt_q == c_cnt_last) begin
               cnt_d = '0;
               if (!write_q) begin
                  hw2_d = data;
               end
               state_d = ST_DONE;
            end else begin
               cnt_d = cnt_q + c_cnt_w'(1);
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Core handshake, response formatting and SRAM strobe decode.
   always_comb begin
      req_ready  = (state_q == ST_IDLE);
      resp_valid = (state_q == ST_DONE);
      resp_err   = (state_q == ST_DONE) && err_q;
      resp_rdata = '0;
      w_byte     = lane_q ? hw1_q[7:0] : hw1_q[15:8];
      if ((state_q == ST_DONE) && !err_q && !write_q) begin
         case (size_q)
            c_size_byte: resp_rdata = {{24{sgn_q & w_byte[7]}}, w_byte};
            c_size_half: resp_rdata = {{16{sgn_q & hw1_q[15]}}, hw1_q};
            c_size_word: resp_rdata = {hw1_q, hw2_q};
            default:     resp_rdata = '0;
         endcase
      end

      w_phase = (state_q == ST_PH1) || (state_q == ST_PH2);
      chip_en = ~w_phase;
      oute    = ~(w_phase & ~write_q);
      wre     = ~(w_phase & write_q);
      hb_mask = ~(w_phase & ((size_q != c_size_byte) | ~lane_q));
      lb_mask = ~(w_phase & ((size_q != c_size_byte) | lane_q));
      addr    = (state_q == ST_PH2) ? haddr_q + ADDR_W'(1) : haddr_q;

      // Data is only ever driven in write phases, where oute is high.
      w_drive = w_phase & write_q;
      if (state_q == ST_PH2) begin
         w_wr_half = wdata_q[15:0];
      end else if (size_q == c_size_word) begin
         w_wr_half = wdata_q[31:16];
      end else if (size_q == c_size_byte) begin
         w_wr_half = {wdata_q[7:0], wdata_q[7:0]};
      end else begin
         w_wr_half = wdata_q[15:0];
      end
   end

   assign data = w_drive ? w_wr_half : 16'hzzzz;

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_bus_master
// Description : Self-checking bench for mem_bus_master with an SRAM model on
//               the bus and a byte-addressed reference memory for expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_bus_master;

   localparam int ADDR_W = 18;
   localparam int N      = 2;
   localparam logic [31:0] c_amask = 32'h0007_FFFF;

   logic              clock = 1'b0;
   logic              reset = 1'b0;
   logic              req_valid = 1'b0;
   logic              req_write = 1'b0;
   logic              req_signed = 1'b0;
   logic [1:0]        req_size = 2'd0;
   logic [31:0]       req_addr = '0;
   logic [31:0]       req_wdata = '0;
   logic              req_ready, resp_valid, resp_err;
   logic [31:0]       resp_rdata;
   logic [ADDR_W-1:0] addr;
   wire  [15:0]       data;
   logic              wre, oute, chip_en, hb_mask, lb_mask;

   int vectors = 0;
   int errors  = 0;

   // per-cycle trace of one transaction: {chip_en, oute, wre, hb_mask, lb_mask}
   logic [4:0]        tr_strb [0:16];
   logic [ADDR_W-1:0] tr_addr [0:16];
   logic [15:0]       tr_data [0:16];

   logic [15:0] sram [0:(1<<ADDR_W)-1];
   logic [7:0]  ref_mem [int];

   mem_bus_master #(.ADDR_W(ADDR_W), .ACCESS_CYCLES(N)) dut (
      .clock(clock), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
      .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_err(resp_err),
      .resp_rdata(resp_rdata), .addr(addr), .data(data), .wre(wre),
      .oute(oute), .chip_en(chip_en), .hb_mask(hb_mask), .lb_mask(lb_mask)
   );

   always #5 clock = ~clock;

   // SRAM device model
   assign data = (!chip_en && !oute) ? sram[addr] : 16'hzzzz;
   always @(posedge clock) begin
      if (!chip_en && !wre) begin
         if (!hb_mask) sram[addr][15:8] <= data[15:8];
         if (!lb_mask) sram[addr][7:0]  <= data[7:0];
      end
   end

   // ---------------- reference model (byte-addressed, big-endian) ----------
   function automatic bit ref_bad(input logic [1:0] sz, input logic [31:0] a);
      return (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00);
   endfunction

   function automatic int ref_lat(input logic [1:0] sz, input logic [31:0] a);
      if (ref_bad(sz, a)) return 1;
      return (sz == 2'd2) ? 2*N + 2 : N + 1;
   endfunction

   function automatic int ref_bus_cycles(input logic [1:0] sz, input logic [31:0] a);
      if (ref_bad(sz, a)) return 0;
      return (sz == 2'd2) ? 2*N : N;
   endfunction

   function automatic void ref_store(input logic [1:0] sz, input logic [31:0] a,
                                     input logic [31:0] wd);
      int nb;
      nb = 1 << sz;
      for (int i = 0; i < nb; i++)
         ref_mem[int'((a + 32'(i)) & c_amask)] = wd[8*(nb-1-i) +: 8];
   endfunction

   function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic sg,
                                            input logic [31:0] a);
      logic [31:0] v;
      int nb, k;
      v  = '0;
      nb = 1 << sz;
      for (int i = 0; i < nb; i++) begin
         k = int'((a + 32'(i)) & c_amask);
         v = (v << 8) | (ref_mem.exists(k) ? {24'h0, ref_mem[k]} : 32'h0);
      end
      if (sg && sz == 2'd0 && v[7])  v = v | 32'hFFFF_FF00;
      if (sg && sz == 2'd1 && v[15]) v = v | 32'hFFFF_0000;
      return v;
   endfunction

   // ---------------- transaction driver / recorder -------------------------
   task automatic issue(input logic wr, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd);
      int n;
      req_write = wr; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
      req_valid = 1'b1;
      n = 0;
      while (req_ready !== 1'b1 && n < 20) begin
         @(negedge clock);
         n++;
      end
      vectors++;
      if (req_ready !== 1'b1)
         $display("FAIL accept_timeout: req_ready=%b required 1", req_ready);
      if (req_ready !== 1'b1) errors++;
      @(posedge clock);
      #1;
      // scramble request fields while busy; they must be ignored
      req_valid  = 1'b0;
      req_write  = 1'($urandom);
      req_size   = 2'($urandom);
      req_signed = 1'($urandom);
      req_addr   = $urandom;
      req_wdata  = $urandom;
   endtask

   task automatic collect(output int lat, output logic [31:0] rd, output logic er);
      lat = 0; rd = '0; er = 1'b0;
      for (int k = 1; k <= 16; k++) begin
         @(negedge clock);
         tr_strb[k] = {chip_en, oute, wre, hb_mask, lb_mask};
         tr_addr[k] = addr;
         tr_data[k] = data;
         if (resp_valid === 1'b1) begin
            lat = k; rd = resp_rdata; er = resp_err;
            break;
         end
      end
   endtask

   // ---------------- tests -------------------------------------------------
   task automatic test_reset();
      logic bad;
      reset = 1'b0;
      repeat (3) @(negedge clock);
      vectors++;
      if ({chip_en, oute, wre, hb_mask, lb_mask} !== 5'h1F) begin
         errors++;
         $display("FAIL reset_strobes: got %b required 11111", {chip_en, oute, wre, hb_mask, lb_mask});
      end
      vectors++;
      if ({req_ready, resp_valid, resp_err} !== 3'b100) begin
         errors++;
         $display("FAIL reset_handshake: got %b required 100", {req_ready, resp_valid, resp_err});
      end
      vectors++;
      if (resp_rdata !== 32'h0 || addr !== '0) begin
         errors++;
         $display("FAIL reset_rdata_addr: got %h/%h required 0/0", resp_rdata, addr);
      end
      reset = 1'b1;
      bad = 1'b0;
      repeat (4) begin
         @(negedge clock);
         if ({chip_en, oute, wre, hb_mask, lb_mask} !== 5'h1F || resp_valid !== 1'b0) bad = 1'b1;
      end
      vectors++;
      if (bad) begin
         errors++;
         $display("FAIL idle_quiet: bus activity=%b required 0", bad);
      end
   endtask

   task automatic test_word_store_load();
      int lat; logic [31:0] rd; logic er;
      issue(1'b1, 2'd2, 1'b0, 32'h40, 32'hDEADBEEF);
      collect(lat, rd, er);
      ref_store(2'd2, 32'h40, 32'hDEADBEEF);
      vectors++;
      if (lat !== ref_lat(2'd2, 32'h40) || er !== 1'b0 || rd !== 32'h0) begin
         errors++;
         $display("FAIL word_store_resp: lat=%0d err=%b rdata=%h required %0d/0/0", lat, er, rd, ref_lat(2'd2, 32'h40));
      end
      vectors++;
      if ({sram[18'h20], sram[18'h21]} !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL word_store_mem: got %h required deadbeef", {sram[18'h20], sram[18'h21]});
      end
      vectors++;
      if ({tr_strb[1][2], tr_strb[2][2], tr_strb[3][2], tr_strb[4][2], tr_strb[5][2], tr_strb[3][4]} !== 6'b001001) begin
         errors++;
         $display("FAIL word_store_wre_pattern: got %b required 001001",
                  {tr_strb[1][2], tr_strb[2][2], tr_strb[3][2], tr_strb[4][2], tr_strb[5][2], tr_strb[3][4]});
      end
      vectors++;
      if ({tr_addr[1], tr_addr[4]} !== {18'h20, 18'h21} || {tr_data[2], tr_data[5]} !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL word_store_addr_data: addr %h/%h data %h/%h required 20/21 dead/beef",
                  tr_addr[1], tr_addr[4], tr_data[2], tr_data[5]);
      end
      issue(1'b0, 2'd2, 1'b0, 32'h40, $urandom);
      collect(lat, rd, er);
      vectors++;
      if (lat !== 6 || er !== 1'b0 || rd !== ref_load(2'd2, 1'b0, 32'h40)) begin
         errors++;
         $display("FAIL word_load: lat=%0d err=%b rdata=%h required 6/0/%h", lat, er, rd, ref_load(2'd2, 1'b0, 32'h40));
      end
   endtask

   task automatic test_byte();
      int lat; logic [31:0] rd; logic er;
      issue(1'b1, 2'd0, 1'b0, 32'h43, 32'h1234567F);
      collect(lat, rd, er);
      ref_store(2'd0, 32'h43, 32'h1234567F);
      vectors++;
      if (lat !== N + 1 || {tr_strb[1][1], tr_strb[1][0]} !== 2'b10 || tr_data[1] !== 16'h7F7F) begin
         errors++;
         $display("FAIL byte_store_bus: lat=%0d masks=%b data=%h required %0d/10/7f7f",
                  lat, {tr_strb[1][1], tr_strb[1][0]}, tr_data[1], N + 1);
      end
      vectors++;
      if (sram[18'h21] !== 16'hBE7F) begin
         errors++;
         $display("FAIL byte_store_mem: got %h required be7f", sram[18'h21]);
      end
      for (int s = 0; s < 2; s++) begin
         issue(1'b0, 2'd0, 1'(s == 0), 32'h42, $urandom);
         collect(lat, rd, er);
         vectors++;
         if (lat !== N + 1 || er !== 1'b0 || rd !== ref_load(2'd0, 1'(s == 0), 32'h42)) begin
            errors++;
            $display("FAIL byte_load_signed%0d: lat=%0d rdata=%h required %0d/%h",
                     (s == 0), lat, rd, N + 1, ref_load(2'd0, 1'(s == 0), 32'h42));
         end
      end
   endtask

   task automatic test_misaligned();
      int lat; logic [31:0] rd; logic er;
      logic [1:0]  sz_t [0:4];
      logic [31:0] a_t  [0:4];
      sz_t[0] = 2'd1; a_t[0] = 32'h41;
      sz_t[1] = 2'd2; a_t[1] = 32'h42;
      sz_t[2] = 2'd3; a_t[2] = 32'h40;
      sz_t[3] = 2'd2; a_t[3] = 32'h7FFFE;
      sz_t[4] = 2'd1; a_t[4] = 32'h43;
      for (int i = 0; i < 5; i++) begin
         issue(1'(i == 4), sz_t[i], 1'b1, a_t[i], 32'hFFFF_FFFF);
         collect(lat, rd, er);
         vectors++;
         if (lat !== 1 || er !== 1'b1 || rd !== 32'h0 || tr_strb[1] !== 5'h1F) begin
            errors++;
            $display("FAIL misaligned_%0d: lat=%0d err=%b rdata=%h strobes=%b required 1/1/0/11111",
                     i, lat, er, rd, tr_strb[1]);
         end
      end
      vectors++;
      if (sram[18'h21] !== 16'hBE7F) begin
         errors++;
         $display("FAIL misaligned_no_write: got %h required be7f", sram[18'h21]);
      end
   endtask

   task automatic test_wrap();
      int lat; logic [31:0] rd, wd; logic er;
      wd = $urandom;
      issue(1'b1, 2'd2, 1'b0, 32'h7FFFC, wd);
      collect(lat, rd, er);
      ref_store(2'd2, 32'h7FFFC, wd);
      vectors++;
      if (tr_addr[1] !== 18'h3FFFE || tr_addr[4] !== 18'h3FFFF) begin
         errors++;
         $display("FAIL wrap_word_addr: got %h/%h required 3fffe/3ffff", tr_addr[1], tr_addr[4]);
      end
      issue(1'b0, 2'd1, 1'b1, 32'h7FFFE, $urandom);
      collect(lat, rd, er);
      vectors++;
      if (tr_addr[1] !== 18'h3FFFF || lat !== N + 1 || rd !== ref_load(2'd1, 1'b1, 32'h7FFFE)) begin
         errors++;
         $display("FAIL wrap_half_load: addr=%h lat=%0d rdata=%h required 3ffff/%0d/%h",
                  tr_addr[1], lat, rd, N + 1, ref_load(2'd1, 1'b1, 32'h7FFFE));
      end
      issue(1'b0, 2'd2, 1'b0, 32'h8_0040, $urandom);
      collect(lat, rd, er);
      vectors++;
      if (rd !== ref_load(2'd2, 1'b0, 32'h8_0040) || tr_addr[1] !== 18'h20) begin
         errors++;
         $display("FAIL alias_word_load: rdata=%h addr=%h required %h/00020",
                  rd, tr_addr[1], ref_load(2'd2, 1'b0, 32'h8_0040));
      end
   endtask

   task automatic test_reset_midflight();
      int lat; logic [31:0] rd; logic er; logic bad;
      issue(1'b1, 2'd2, 1'b0, 32'h80, 32'h11223344);
      collect(lat, rd, er);
      ref_store(2'd2, 32'h80, 32'h11223344);
      issue(1'b1, 2'd2, 1'b0, 32'h80, 32'hAABBCCDD);
      repeat (3) @(negedge clock);
      @(posedge clock);
      #2;
      vectors++;
      if (wre !== 1'b0 || addr !== 18'h41) begin
         errors++;
         $display("FAIL midflight_ph2_active: wre=%b addr=%h required 0/41", wre, addr);
      end
      reset = 1'b0;
      #1;
      vectors++;
      if ({chip_en, oute, wre, hb_mask, lb_mask} !== 5'h1F || resp_valid !== 1'b0) begin
         errors++;
         $display("FAIL midflight_reset_strobes: got %b rv=%b required 11111/0",
                  {chip_en, oute, wre, hb_mask, lb_mask}, resp_valid);
      end
      bad = 1'b0;
      repeat (2) begin
         @(negedge clock);
         if (resp_valid !== 1'b0) bad = 1'b1;
      end
      reset = 1'b1;
      repeat (3) begin
         @(negedge clock);
         if (resp_valid !== 1'b0) bad = 1'b1;
      end
      vectors++;
      if (bad || req_ready !== 1'b1) begin
         errors++;
         $display("FAIL midflight_after_release: spurious_resp=%b ready=%b required 0/1", bad, req_ready);
      end
      // only the first phase reached the SRAM before reset
      ref_store(2'd1, 32'h80, 32'h0000AABB);
      issue(1'b0, 2'd2, 1'b0, 32'h80, $urandom);
      collect(lat, rd, er);
      vectors++;
      if (lat !== 6 || er !== 1'b0 || rd !== ref_load(2'd2, 1'b0, 32'h80)) begin
         errors++;
         $display("FAIL midflight_followup_load: lat=%0d rdata=%h required 6/%h", lat, rd, ref_load(2'd2, 1'b0, 32'h80));
      end
   endtask

   task automatic test_random();
      int lat, nbus; logic [31:0] rd, a, wd, exp; logic er, wr, sg, cont; logic [1:0] sz;
      for (int i = 0; i < 16; i++) begin
         wd = $urandom;
         issue(1'b1, 2'd2, 1'b0, 32'h200 + 32'(4*i), wd);
         collect(lat, rd, er);
         ref_store(2'd2, 32'h200 + 32'(4*i), wd);
      end
      for (int i = 0; i < 40; i++) begin
         wr = 1'($urandom);
         sz = 2'($urandom_range(0, 3));
         sg = 1'($urandom);
         a  = ($urandom & 32'hFFF8_0000) | (32'h200 + $urandom_range(0, 63));
         wd = $urandom;
         issue(wr, sz, sg, a, wd);
         collect(lat, rd, er);
         exp = (wr || ref_bad(sz, a)) ? 32'h0 : ref_load(sz, sg, a);
         if (wr && !ref_bad(sz, a)) ref_store(sz, a, wd);
         nbus = 0; cont = 1'b0;
         for (int k = 1; k <= lat; k++) begin
            if (tr_strb[k][4] == 1'b0) nbus++;
            if (tr_strb[k][2] == 1'b0 && tr_strb[k][3] == 1'b0) cont = 1'b1;
         end
         vectors++;
         if (lat !== ref_lat(sz, a) || er !== ref_bad(sz, a) || rd !== exp
             || nbus !== ref_bus_cycles(sz, a) || cont) begin
            errors++;
            $display("FAIL random_%0d wr=%b sz=%0d a=%h: lat=%0d err=%b rdata=%h bus=%0d cont=%b required %0d/%b/%h/%0d/0",
                     i, wr, sz, a, lat, er, rd, nbus, cont, ref_lat(sz, a), ref_bad(sz, a), exp, ref_bus_cycles(sz, a));
         end
      end
   endtask

   initial begin
      test_reset();
      test_word_store_load();
      test_byte();
      test_misaligned();
      test_wrap();
      test_reset_midflight();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
`default_nettype wire
